// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> hazard unit signal bundle.
// The pipeline side (master) drives the per-stage decode/control fields and
// the long-latency unit issue/writeback events; the hazard unit (slave)
// returns the stall/bubble controls and its registered scoreboard view.
// Optional macro HAZARD_PERF_EN adds the stallCycles/stallLoadUse counters.
interface hazard_scoreboard_if #(
  parameter int REG_IDX_WIDTH = 5,
  parameter int MAX_PENDING   = 2
);
  localparam int NUM_REGS = 1 << REG_IDX_WIDTH;
  localparam int CNT_W    = $clog2(MAX_PENDING + 1);

  logic [REG_IDX_WIDTH-1:0] readAddr1_ID;
  logic [REG_IDX_WIDTH-1:0] readAddr2_ID;
  logic                     useRs1_ID;
  logic                     useRs2_ID;
  logic [REG_IDX_WIDTH-1:0] writeAddr_ID;
  logic                     regWrite_ID;
  logic                     isBranch_ID;
  logic                     isLong_ID;
  logic                     regWrite_EX;
  logic                     memRead_EX;
  logic [REG_IDX_WIDTH-1:0] writeAddr_EX;
  logic                     memRead_MEM;
  logic [REG_IDX_WIDTH-1:0] writeAddr_MEM;
  logic                     issueLong;
  logic [REG_IDX_WIDTH-1:0] issueAddr;
  logic                     longDone;
  logic [REG_IDX_WIDTH-1:0] longDoneAddr;
  logic                     stall_PC;
  logic                     stall_IFID;
  logic                     bubble_IDEX;
  logic [NUM_REGS-1:0]      pendingMask;
  logic [CNT_W-1:0]         outstanding;
`ifdef HAZARD_PERF_EN
  logic [31:0]              stallCycles;
  logic [31:0]              stallLoadUse;
`endif

  modport master (
    output readAddr1_ID, readAddr2_ID, useRs1_ID, useRs2_ID,
    output writeAddr_ID, regWrite_ID, isBranch_ID, isLong_ID,
    output regWrite_EX, memRead_EX, writeAddr_EX,
    output memRead_MEM, writeAddr_MEM,
    output issueLong, issueAddr, longDone, longDoneAddr,
    input  stall_PC, stall_IFID, bubble_IDEX, pendingMask, outstanding
`ifdef HAZARD_PERF_EN
    , input stallCycles, stallLoadUse
`endif
  );

  modport slave (
    input  readAddr1_ID, readAddr2_ID, useRs1_ID, useRs2_ID,
    input  writeAddr_ID, regWrite_ID, isBranch_ID, isLong_ID,
    input  regWrite_EX, memRead_EX, writeAddr_EX,
    input  memRead_MEM, writeAddr_MEM,
    input  issueLong, issueAddr, longDone, longDoneAddr,
    output stall_PC, stall_IFID, bubble_IDEX, pendingMask, outstanding
`ifdef HAZARD_PERF_EN
    , output stallCycles, stallLoadUse
`endif
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard detection and stall control for the 5-stage core.
// Covers hazards forwarding cannot resolve: load-use, branch operands still
// in EX/MEM for the ID compare, and RAW/WAW/structural hazards against the
// long-latency (mul/div) unit, tracked by a per-register pending scoreboard.
// Any hazard holds PC and IF/ID and bubbles ID/EX in the same cycle.
// Optional macro HAZARD_PERF_EN adds 32-bit stallCycles/stallLoadUse counters.
module hazard_scoreboard #(
  parameter int REG_IDX_WIDTH = 5,
  parameter int MAX_PENDING   = 2
) (
  input logic               clk,
  input logic               rstn,
  hazard_scoreboard_if.slave bus
);
  localparam int NUM_REGS = 1 << REG_IDX_WIDTH;
  localparam int CNT_W    = $clog2(MAX_PENDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

  typedef logic [REG_IDX_WIDTH-1:0] idx_t;

  // True when the ID instruction reads register a (x0 never matches).
  function automatic logic src_hit(input idx_t a, input logic u1, input idx_t r1,
                                   input logic u2, input idx_t r2);
    return (a != '0) && ((u1 && (r1 == a)) || (u2 && (r2 == a)));
  endfunction

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [NUM_REGS-1:0] set_vec, clr_vec, pending_eff;
  logic                do_set, do_clr;
  logic                load_use, br_ex, br_mem, sb_raw, issue_raw, waw, struct_hz;
  logic                stall;

  // Issue/writeback events decoded to one-hot vectors; x0 is never tracked.
  always_comb begin
    do_set  = bus.issueLong && (bus.issueAddr != '0);
    do_clr  = bus.longDone && (bus.longDoneAddr != '0);
    set_vec = '0;
    clr_vec = '0;
    if (do_set) set_vec[bus.issueAddr] = 1'b1;
    if (do_clr) clr_vec[bus.longDoneAddr] = 1'b1;
    // A register being written back this cycle is already readable (write-first).
    pending_eff = pending_q & ~clr_vec;
  end

  // Hazard terms; each one alone is enough to stall.
  always_comb begin
    load_use  = bus.memRead_EX &&
                src_hit(bus.writeAddr_EX, bus.useRs1_ID, bus.readAddr1_ID,
                        bus.useRs2_ID, bus.readAddr2_ID);
    br_ex     = bus.isBranch_ID && bus.regWrite_EX &&
                src_hit(bus.writeAddr_EX, bus.useRs1_ID, bus.readAddr1_ID,
                        bus.useRs2_ID, bus.readAddr2_ID);
    br_mem    = bus.isBranch_ID && bus.memRead_MEM &&
                src_hit(bus.writeAddr_MEM, bus.useRs1_ID, bus.readAddr1_ID,
                        bus.useRs2_ID, bus.readAddr2_ID);
    sb_raw    = (bus.useRs1_ID && (bus.readAddr1_ID != '0) && pending_eff[bus.readAddr1_ID]) ||
                (bus.useRs2_ID && (bus.readAddr2_ID != '0) && pending_eff[bus.readAddr2_ID]);
    // The bit for an op issuing this cycle is not in pending_q yet.
    issue_raw = bus.issueLong &&
                src_hit(bus.issueAddr, bus.useRs1_ID, bus.readAddr1_ID,
                        bus.useRs2_ID, bus.readAddr2_ID);
    waw       = bus.regWrite_ID && (bus.writeAddr_ID != '0) && pending_eff[bus.writeAddr_ID];
    struct_hz = bus.isLong_ID && (count_q == MAX_CNT) && !bus.longDone;
    stall     = load_use | br_ex | br_mem | sb_raw | issue_raw | waw | struct_hz;
  end

  // Next scoreboard state: clear then set, so a same-address issue stays pending.
  always_comb begin
    pending_d = (pending_q & ~clr_vec) | set_vec;
    count_d   = count_q;
    if (do_set && !do_clr) begin
      if (count_q != MAX_CNT) count_d = count_q + 1'b1;
    end else if (do_clr && !do_set) begin
      if (count_q != '0) count_d = count_q - 1'b1;
    end
  end

  // Scoreboard and in-flight count registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign bus.stall_PC    = stall;
  assign bus.stall_IFID  = stall;
  assign bus.bubble_IDEX = stall;
  assign bus.pendingMask = pending_q;
  assign bus.outstanding = count_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_load_use_q;

  // Free-running wrap-around stall counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles_q   <= '0;
      stall_load_use_q <= '0;
    end else begin
      if (stall)    stall_cycles_q   <= stall_cycles_q + 32'd1;
      if (load_use) stall_load_use_q <= stall_load_use_q + 32'd1;
    end
  end

  assign bus.stallCycles  = stall_cycles_q;
  assign bus.stallLoadUse = stall_load_use_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a rule-level model (pending array
// plus clamped count) checked every cycle, plus literal expectations.
module tb_hazard_scoreboard;
  localparam int W    = 5;
  localparam int MAXP = 2;

  logic clk;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 0;

  hazard_scoreboard_if #(.REG_IDX_WIDTH(W), .MAX_PENDING(MAXP)) bus ();

  hazard_scoreboard #(.REG_IDX_WIDTH(W), .MAX_PENDING(MAXP)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  bit model_pend[32];
  int model_cnt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) model_pend[i] = 0;
      model_cnt = 0;
    end else begin
      int inc, dec;
      inc = (bus.issueLong && bus.issueAddr != 0) ? 1 : 0;
      dec = (bus.longDone && bus.longDoneAddr != 0) ? 1 : 0;
      if (dec == 1) model_pend[bus.longDoneAddr] = 0;
      if (inc == 1) model_pend[bus.issueAddr] = 1;
      model_cnt = model_cnt + inc - dec;
      if (model_cnt < 0) model_cnt = 0;
      if (model_cnt > MAXP) model_cnt = MAXP;
    end
  end

  function automatic bit reads(int a);
    if (a == 0) return 0;
    return (bus.useRs1_ID && int'(bus.readAddr1_ID) == a) ||
           (bus.useRs2_ID && int'(bus.readAddr2_ID) == a);
  endfunction

  function automatic bit done_now(int a);
    return bus.longDone && int'(bus.longDoneAddr) == a;
  endfunction

  function automatic bit model_stall();
    bit s = 0;
    if (bus.memRead_EX && reads(bus.writeAddr_EX)) s = 1;
    if (bus.isBranch_ID && bus.regWrite_EX && reads(bus.writeAddr_EX)) s = 1;
    if (bus.isBranch_ID && bus.memRead_MEM && reads(bus.writeAddr_MEM)) s = 1;
    for (int a = 1; a < 32; a++)
      if (model_pend[a] && !done_now(a) && reads(a)) s = 1;
    if (bus.issueLong && reads(bus.issueAddr)) s = 1;
    if (bus.regWrite_ID && bus.writeAddr_ID != 0 && model_pend[bus.writeAddr_ID] &&
        !done_now(bus.writeAddr_ID)) s = 1;
    if (bus.isLong_ID && model_cnt == MAXP && !bus.longDone) s = 1;
    return s;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    for (int a = 0; a < 32; a++) m[a] = model_pend[a];
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard compare against the model every cycle out of reset
  always @(negedge clk) begin
    if (cmp_en && rstn) begin
      bit s;
      s = model_stall();
      chk("m_stall_PC",    64'(bus.stall_PC),    64'(s));
      chk("m_stall_IFID",  64'(bus.stall_IFID),  64'(s));
      chk("m_bubble_IDEX", 64'(bus.bubble_IDEX), 64'(s));
      chk("m_pendingMask", 64'(bus.pendingMask), 64'(model_mask()));
      chk("m_outstanding", 64'(bus.outstanding), 64'(model_cnt));
    end
  end

  // Driver tasks
  task automatic idle();
    bus.readAddr1_ID = '0; bus.readAddr2_ID = '0;
    bus.useRs1_ID = 0; bus.useRs2_ID = 0;
    bus.writeAddr_ID = '0; bus.regWrite_ID = 0;
    bus.isBranch_ID = 0; bus.isLong_ID = 0;
    bus.regWrite_EX = 0; bus.memRead_EX = 0; bus.writeAddr_EX = '0;
    bus.memRead_MEM = 0; bus.writeAddr_MEM = '0;
    bus.issueLong = 0; bus.issueAddr = '0;
    bus.longDone = 0; bus.longDoneAddr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_reads(input int r1, input int r2);
    bus.useRs1_ID = 1; bus.readAddr1_ID = W'(r1);
    bus.useRs2_ID = 1; bus.readAddr2_ID = W'(r2);
  endtask

  task automatic chk_stall(input string name, input bit exp);
    @(negedge clk);
    chk(name, 64'(bus.stall_PC), 64'(exp));
  endtask

  initial begin
    idle();
    rstn = 0;
    tick(); tick();
    @(negedge clk);
    chk("rst_mask",  64'(bus.pendingMask), 64'h0);
    chk("rst_count", 64'(bus.outstanding), 64'h0);
    chk("rst_stall", 64'(bus.stall_PC),    64'h0);
    tick();
    rstn = 1;
    cmp_en = 1;
    tick();

    // load-use: lw x5 in EX, add reads x5
    bus.memRead_EX = 1; bus.regWrite_EX = 1; bus.writeAddr_EX = 5;
    id_reads(5, 1);
    chk_stall("lu_c1", 1);
    tick();
    bus.memRead_EX = 0; bus.regWrite_EX = 0; bus.writeAddr_EX = 0;
    bus.memRead_MEM = 1; bus.writeAddr_MEM = 5;
    chk_stall("lu_c2", 0);
    tick(); idle();

    // beq x6 behind lw x6: two stall cycles
    bus.isBranch_ID = 1; id_reads(2, 6);
    bus.memRead_EX = 1; bus.regWrite_EX = 1; bus.writeAddr_EX = 6;
    chk_stall("br_ld_c1", 1);
    tick();
    bus.memRead_EX = 0; bus.regWrite_EX = 0; bus.writeAddr_EX = 0;
    bus.memRead_MEM = 1; bus.writeAddr_MEM = 6;
    chk_stall("br_ld_c2", 1);
    tick();
    bus.memRead_MEM = 0; bus.writeAddr_MEM = 0;
    chk_stall("br_ld_c3", 0);
    tick();

    // beq x6 behind add x6: one stall cycle
    bus.regWrite_EX = 1; bus.writeAddr_EX = 6;
    chk_stall("br_alu_c1", 1);
    tick();
    bus.regWrite_EX = 0; bus.writeAddr_EX = 0; bus.writeAddr_MEM = 6;
    chk_stall("br_alu_c2", 0);
    tick(); idle();

    // issue x7, reader waits until the done cycle
    bus.issueLong = 1; bus.issueAddr = 7;
    bus.useRs1_ID = 1; bus.readAddr1_ID = 7;
    chk_stall("iss_same", 1);
    tick();
    bus.issueLong = 0; bus.issueAddr = 0;
    @(negedge clk);
    chk("iss7_mask",  64'(bus.pendingMask), 64'h80);
    chk("iss7_count", 64'(bus.outstanding), 64'd1);
    chk("raw7_wait",  64'(bus.stall_PC),    64'd1);
    tick();
    chk_stall("raw7_wait2", 1);
    tick();
    bus.longDone = 1; bus.longDoneAddr = 7;
    chk_stall("raw7_done", 0);
    tick();
    bus.longDone = 0; bus.longDoneAddr = 0;
    @(negedge clk);
    chk("rel7_mask",  64'(bus.pendingMask), 64'h0);
    chk("rel7_count", 64'(bus.outstanding), 64'd0);
    tick(); idle();

    // same-cycle done/issue on x9: set wins, count unchanged
    bus.issueLong = 1; bus.issueAddr = 9;
    tick();
    bus.issueLong = 1; bus.issueAddr = 9; bus.longDone = 1; bus.longDoneAddr = 9;
    tick();
    idle();
    @(negedge clk);
    chk("x9_mask",  64'(bus.pendingMask), 64'h200);
    chk("x9_count", 64'(bus.outstanding), 64'd1);
    tick();
    bus.longDone = 1; bus.longDoneAddr = 9;
    tick(); idle();

    // x0 is ignored on issue and done; done with count 0 ignored
    bus.issueLong = 1; bus.issueAddr = 0;
    tick(); idle();
    bus.longDone = 1; bus.longDoneAddr = 5;
    tick(); idle();
    @(negedge clk);
    chk("x0_count", 64'(bus.outstanding), 64'd0);
    chk("x0_mask",  64'(bus.pendingMask), 64'h0);
    tick();

    // structural: fill both slots, then long op in ID
    bus.issueLong = 1; bus.issueAddr = 3;
    tick();
    bus.issueAddr = 4;
    @(negedge clk);
    chk("st_count1", 64'(bus.outstanding), 64'd1);
    tick();
    idle();
    bus.isLong_ID = 1;
    @(negedge clk);
    chk("st_count2", 64'(bus.outstanding), 64'd2);
    chk("st_stall",  64'(bus.stall_PC),    64'd1);
    tick();
    bus.isLong_ID = 0; bus.regWrite_ID = 1; bus.writeAddr_ID = 3;
    chk_stall("waw_x3", 1);
    tick();
    bus.regWrite_ID = 0; bus.writeAddr_ID = 0;
    bus.isLong_ID = 1; bus.longDone = 1; bus.longDoneAddr = 3;
    chk_stall("st_done", 0);
    tick();
    idle();
    @(negedge clk);
    chk("st_count3", 64'(bus.outstanding), 64'd1);
    tick();

    // refill to 2 with bits 3,4, then async reset mid-cycle
    bus.issueLong = 1; bus.issueAddr = 3;
    tick(); idle();
    @(negedge clk);
    chk("pre_rst_mask", 64'(bus.pendingMask), 64'h18);
    #2;
    rstn = 0;
    #1;
    chk("arst_mask",  64'(bus.pendingMask), 64'h0);
    chk("arst_count", 64'(bus.outstanding), 64'd0);
    chk("arst_stall", 64'(bus.stall_PC),    64'd0);
    tick();
    rstn = 1;
    tick();

    // x0 source with load to x0 in EX never stalls
    bus.memRead_EX = 1; bus.regWrite_EX = 1; bus.writeAddr_EX = 0;
    id_reads(0, 0); bus.isBranch_ID = 1;
    chk_stall("x0_lu", 0);
    tick(); idle();
    tick();

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Hazard detection and stall control for the 5-stage core, covering every hazard the forwarding paths cannot resolve. These are load-use, a branch operand still in flight for ID compare, and destinations of long-latency ops (mul/div unit) that are pending writeback. It drives the PC/IF-ID hold and ID/EX bubble, and keeps a per-register pending scoreboard for the long-latency unit.

Parameters:
REG_IDX_WIDTH, 5, register index width; NUM_REGS = 2**REG_IDX_WIDTH
MAX_PENDING, 2, max outstanding long-latency ops (1..NUM_REGS-1)

Ports:
clk  in  1  core clock, rising edge
rstn  in  1  asynchronous active-low reset
readAddr1_ID  in  REG_IDX_WIDTH  rs1 of instruction in ID
readAddr2_ID  in  REG_IDX_WIDTH  rs2 of instruction in ID
useRs1_ID, useRs2_ID  in  1 each  ID instruction actually reads rs1/rs2
writeAddr_ID  in  REG_IDX_WIDTH  rd of ID instruction
regWrite_ID  in  1  ID instruction writes rd
isBranch_ID  in  1  ID instruction is a branch (compares in ID)
isLong_ID  in  1  ID instruction is a long-latency op
regWrite_EX, memRead_EX  in  1 each  EX-stage control
writeAddr_EX  in  REG_IDX_WIDTH  rd in EX
memRead_MEM  in  1  load in MEM
writeAddr_MEM  in  REG_IDX_WIDTH  rd in MEM
issueLong  in  1  long op leaves EX into the unit this cycle
issueAddr  in  REG_IDX_WIDTH  its rd
longDone  in  1  unit writes back this cycle (regfile is write-first)
longDoneAddr  in  REG_IDX_WIDTH  rd being written back
stall_PC, stall_IFID  out  1 each  hold PC and IF/ID
bubble_IDEX  out  1  insert NOP into ID/EX
pendingMask  out  NUM_REGS  registered scoreboard, bit i = xi pending
outstanding  out  clog2(MAX_PENDING+1)  registered count of ops in flight

Behaviour:
- Reset (rstn=0, async): pendingMask=0, outstanding=0; stall outputs follow combinational terms, which are 0 with idle inputs.
- Register 0 never creates a hazard, is never set pending, and is ignored on issue/done.
- src hit(a) = (useRs1_ID && readAddr1_ID==a) || (useRs2_ID && readAddr2_ID==a), a!=0.
- Load-use: memRead_EX && hit(writeAddr_EX) -> stall 1 cycle.
- Branch: isBranch_ID && regWrite_EX && hit(writeAddr_EX) -> stall. isBranch_ID && memRead_MEM && hit(writeAddr_MEM) -> stall. A branch behind a load therefore stalls 2 cycles, behind an ALU op 1 cycle; MEM->ID forwarding covers the rest.
- Scoreboard RAW: hit(a) with pendingMask[a]=1 and not (longDone && longDoneAddr==a) -> stall. Release occurs in the longDone cycle.
- Same-cycle issue: hit(issueAddr) while issueLong=1 -> stall. The bit is not yet visible in pendingMask.
- WAW: regWrite_ID && pendingMask[writeAddr_ID] (same longDone exemption) -> stall.
- Structural: isLong_ID && outstanding==MAX_PENDING && !longDone -> stall.
- Any stall: stall_PC=stall_IFID=bubble_IDEX=1 in the same cycle (combinational).
- Sequential update at posedge:
  - issueLong sets pendingMask[issueAddr].
  - longDone clears pendingMask[longDoneAddr].
  - If both target the same address, set wins (the new issue remains pending).
  - outstanding += issueLong - longDone.
  - Count saturates at 0 (longDone with count 0 is ignored) and at MAX_PENDING (issue when full is a protocol error; count holds).
  - Set/clear with addr 0 do not touch the count.
- Flushes do not clear the scoreboard: issued long ops always complete. The upstream pipeline gates issueLong for killed instructions.

Optional Feature:
HAZARD_PERF_EN:
- Defined: adds output stallCycles (32 bit) and stallLoadUse (32 bit), both registered, reset to 0. stallCycles increments every cycle stall_PC=1; stallLoadUse increments on load-use stall cycles only. Both wrap modulo 2^32.
- Not defined: ports and counters are absent; no other behavioural change.

Test Plan:
lw x5 in EX (memRead_EX=1, writeAddr_EX=5), add reads x5 in ID -> stall_PC=bubble_IDEX=1 for exactly 1 cycle.
beq x6 in ID behind lw x6: cycle1 EX-load stall, cycle2 MEM-load stall -> 2 stall cycles, then 0; behind add x6 -> 1 stall cycle.
issueLong addr 7, next ID reads x7 -> stall each cycle until longDone addr 7; in the longDone cycle stall=0, pendingMask[7]=0 after the edge.
Same cycle longDone addr 9 and issueLong addr 9 -> pendingMask[9]=1 after the edge, outstanding unchanged.
MAX_PENDING=2: issue x3, x4; isLong_ID=1 -> stall until a longDone; outstanding goes 0->1->2->1.
Reset asserted with outstanding=2, pendingMask bits 3,4 set -> immediately 0, no stall; rs=x0 with memRead_EX, writeAddr_EX=0 -> no stall.
